// File: rtl/fetch_unit_seq.sv
// Multi-program PC / instruction-fetch unit with stall, hardware return-address
// stack and sticky stack-error flag; programs run back to back from a start table.
module fetch_unit_seq #(
    parameter int                      PC_W       = 16,
    parameter int                      NUM_PROG   = 3,
    parameter logic [NUM_PROG*PC_W-1:0] PROG_START = {16'd301, 16'd124, 16'd66},
    parameter int                      DONE_ADDR  = 999,
    parameter int                      RAS_DEPTH  = 4
) (
    input  logic                        CLK,
    input  logic                        Init,
    input  logic                        Start,
    input  logic                        Stall,
    input  logic                        Branch_abs,
    input  logic                        Branch_rel_z,
    input  logic                        Branch_rel_nz,
    input  logic                        Branch_call,
    input  logic                        Branch_ret,
    input  logic                        ALU_zero,
    input  logic [PC_W-1:0]             Target,
    output logic [PC_W-1:0]             PC,
    output logic                        DONE,
    output logic                        ALL_DONE,
    output logic [$clog2(NUM_PROG):0]   PROG_IDX,
    output logic                        RAS_ERR
);

    localparam int IDX_W = $clog2(NUM_PROG) + 1;
    localparam int SP_W  = $clog2(RAS_DEPTH + 1);

    localparam logic [PC_W-1:0]  DONE_PC  = PC_W'(DONE_ADDR);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PROG - 1);
    localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        HALTED   = 2'd1,
        FINISHED = 2'd2
    } state_t;

    state_t state;

    // Tables padded to a power of two so the index widths match exactly.
    logic [PC_W-1:0] start_tbl [0:(1<<IDX_W)-1];
    logic [PC_W-1:0] ras       [0:(1<<SP_W)-1];
    logic [SP_W-1:0] sp;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_rel;
    logic            ras_empty;
    logic            ras_full;

    always_comb begin
        for (int unsigned i = 0; i < (1 << IDX_W); i++) begin
            start_tbl[i] = '0;
            if (i < NUM_PROG)
                start_tbl[i] = PROG_START[i*PC_W +: PC_W];
        end
    end

    assign pc_inc    = PC + PC_W'(1);
    assign pc_rel    = PC + Target;
    assign ras_empty = (sp == '0);
    assign ras_full  = (sp == SP_FULL);

    always_ff @(posedge CLK) begin
        if (Init) begin
            state    <= RUN;
            PROG_IDX <= '0;
            PC       <= start_tbl[0];
            DONE     <= 1'b0;
            ALL_DONE <= 1'b0;
            RAS_ERR  <= 1'b0;
            sp       <= '0;
        end else begin
            case (state)
                RUN: begin
                    // Halt detection outranks stall and every branch input.
                    if (PC == DONE_PC) begin
                        DONE <= 1'b1;
                        if (PROG_IDX < LAST_IDX) begin
                            PROG_IDX <= PROG_IDX + IDX_W'(1);
                            state    <= HALTED;
                        end else begin
                            ALL_DONE <= 1'b1;
                            state    <= FINISHED;
                        end
                    end else if (Stall) begin
                        PC <= PC;
                    end else if (Branch_ret) begin
                        if (!ras_empty) begin
                            PC <= ras[sp - SP_W'(1)];
                            sp <= sp - SP_W'(1);
                        end else begin
                            RAS_ERR <= 1'b1;
                            PC      <= pc_inc;
                        end
                    end else if (Branch_call) begin
                        if (!ras_full) begin
                            ras[sp] <= pc_inc;
                            sp      <= sp + SP_W'(1);
                        end else begin
                            RAS_ERR <= 1'b1;
                        end
                        PC <= Target;
                    end else if (Branch_abs) begin
                        PC <= Target;
                    end else if (Branch_rel_z && ALU_zero) begin
                        PC <= pc_rel;
                    end else if (Branch_rel_nz && !ALU_zero) begin
                        PC <= pc_rel;
                    end else begin
                        PC <= pc_inc;
                    end
                end
                HALTED: begin
                    if (Start) begin
                        PC    <= start_tbl[PROG_IDX];
                        DONE  <= 1'b0;
                        sp    <= '0;
                        state <= RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit_seq.sv
// Directed self-checking bench for fetch_unit_seq: reset, free run, relative
// branches, RAS overflow/underflow, stall, wrap, halts and the program sequence.
module tb_fetch_unit_seq;

    logic        CLK = 1'b0;
    logic        Init = 1'b1;
    logic        Start = 1'b0;
    logic        Stall = 1'b0;
    logic        Branch_abs = 1'b0;
    logic        Branch_rel_z = 1'b0;
    logic        Branch_rel_nz = 1'b0;
    logic        Branch_call = 1'b0;
    logic        Branch_ret = 1'b0;
    logic        ALU_zero = 1'b0;
    logic [15:0] Target = '0;
    logic [15:0] PC;
    logic        DONE;
    logic        ALL_DONE;
    logic [2:0]  PROG_IDX;
    logic        RAS_ERR;

    int checks = 0;
    int failures = 0;

    fetch_unit_seq #(
        .PC_W      (16),
        .NUM_PROG  (3),
        .PROG_START({16'd301, 16'd124, 16'd66}),
        .DONE_ADDR (999),
        .RAS_DEPTH (4)
    ) dut (
        .CLK          (CLK),
        .Init         (Init),
        .Start        (Start),
        .Stall        (Stall),
        .Branch_abs   (Branch_abs),
        .Branch_rel_z (Branch_rel_z),
        .Branch_rel_nz(Branch_rel_nz),
        .Branch_call  (Branch_call),
        .Branch_ret   (Branch_ret),
        .ALU_zero     (ALU_zero),
        .Target       (Target),
        .PC           (PC),
        .DONE         (DONE),
        .ALL_DONE     (ALL_DONE),
        .PROG_IDX     (PROG_IDX),
        .RAS_ERR      (RAS_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        Start = 0; Stall = 0; Branch_abs = 0; Branch_rel_z = 0;
        Branch_rel_nz = 0; Branch_call = 0; Branch_ret = 0; ALU_zero = 0;
    endtask

    task automatic jump(input logic [15:0] t);
        Branch_abs = 1; Target = t;
        tick();
        Branch_abs = 0;
    endtask

    logic [15:0] ret_exp [5];

    initial begin
        ret_exp[0] = 201; ret_exp[1] = 201; ret_exp[2] = 201; ret_exp[3] = 81; ret_exp[4] = 82;

        tick();
        Init = 0;
        check("reset_pc", PC, 66);
        check("reset_done", DONE, 0);
        check("reset_all_done", ALL_DONE, 0);
        check("reset_idx", PROG_IDX, 0);
        check("reset_ras_err", RAS_ERR, 0);

        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("free_run_%0d", i), PC, 66 + i);
        end
        check("free_run_done", DONE, 0);

        // Relative branches from PC=70.
        Branch_rel_nz = 1; ALU_zero = 0; Target = 16'hFFFB;
        tick();
        check("rel_nz_taken", PC, 65);
        clear_inputs();
        jump(70);
        Branch_rel_nz = 1; ALU_zero = 1; Target = 16'hFFFB;
        tick();
        check("rel_nz_not_taken", PC, 71);
        clear_inputs();
        Branch_rel_z = 1; ALU_zero = 1; Target = 5;
        tick();
        check("rel_z_taken", PC, 76);
        ALU_zero = 0;
        tick();
        check("rel_z_not_taken", PC, 77);
        Branch_rel_nz = 1; Target = 3;
        tick();
        check("rel_z_fail_nz_taken", PC, 80);
        clear_inputs();

        // Return-address stack: four pushes fit, fifth overflows.
        Branch_call = 1; Target = 200;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("call_pc_%0d", i), PC, 200);
        end
        check("call_no_err", RAS_ERR, 0);
        tick();
        check("call_overflow_pc", PC, 200);
        check("call_overflow_err", RAS_ERR, 1);
        clear_inputs();
        Branch_ret = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("ret_pc_%0d", i), PC, ret_exp[i]);
        end
        check("ret_underflow_err", RAS_ERR, 1);
        clear_inputs();

        // Stall beats a branch.
        jump(90);
        Stall = 1; Branch_abs = 1; Target = 10;
        tick();
        check("stall_hold", PC, 90);
        clear_inputs();

        jump(16'hFFFF);
        tick();
        check("pc_wrap", PC, 0);

        // First halt.
        jump(999);
        check("at_done_addr_pc", PC, 999);
        check("at_done_addr_done", DONE, 0);
        tick();
        check("halt0_done", DONE, 1);
        check("halt0_idx", PROG_IDX, 1);
        check("halt0_all_done", ALL_DONE, 0);
        Branch_abs = 1; Target = 5;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("halted_hold_%0d", i), PC, 999);
        end
        Start = 1;
        tick();
        check("start1_pc", PC, 124);
        check("start1_done", DONE, 0);
        check("start1_ras_err_kept", RAS_ERR, 1);
        clear_inputs();

        // Second halt detected while stalled.
        jump(999);
        Stall = 1;
        tick();
        check("stall_halt_done", DONE, 1);
        check("stall_halt_idx", PROG_IDX, 2);
        check("stall_halt_pc", PC, 999);
        clear_inputs();
        Start = 1;
        tick();
        check("start2_pc", PC, 301);
        clear_inputs();

        // Last program.
        jump(999);
        tick();
        check("final_done", DONE, 1);
        check("final_all_done", ALL_DONE, 1);
        check("final_idx", PROG_IDX, 2);
        Start = 1;
        tick();
        tick();
        check("finished_ignores_start_pc", PC, 999);
        check("finished_ignores_start_all", ALL_DONE, 1);
        clear_inputs();

        Init = 1;
        tick();
        Init = 0;
        check("reinit_pc", PC, 66);
        check("reinit_all_done", ALL_DONE, 0);
        check("reinit_done", DONE, 0);
        check("reinit_idx", PROG_IDX, 0);
        check("reinit_ras_err", RAS_ERR, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit_seq.md
Name: fetch_unit_seq

Overview:
- Parametrised program-counter / instruction-fetch unit; next generation of the single-program PC block.
- Runs NUM_PROG programs back to back from a start-address table, with halt detection at DONE_ADDR and a per-program Start handshake.
- Adds stall, call/return via a hardware return-address stack (RAS), and sticky error reporting.
- Drives the instruction-memory address; the decoder/ALU drive its branch controls.

Parameters:
- PC_W, 16, PC and Target width.
- NUM_PROG, 3, number of programs in the start table (>=1).
- PROG_START, {16'd301,16'd124,16'd66}, packed NUM_PROG*PC_W start table; entry i at bits [i*PC_W +: PC_W].
- DONE_ADDR, 999, PC value that marks end of a program.
- RAS_DEPTH, 4, return-stack entries (>=1).

Ports:
- CLK  in  1  clock; all state changes on posedge only.
- Init  in  1  synchronous active-high reset.
- Start  in  1  launch next program; honoured only in HALTED.
- Stall  in  1  hold PC (no branch, no increment).
- Branch_abs  in  1  PC <= Target.
- Branch_rel_z  in  1  PC <= PC+Target if ALU_zero.
- Branch_rel_nz  in  1  PC <= PC+Target if !ALU_zero.
- Branch_call  in  1  push PC+1, PC <= Target.
- Branch_ret  in  1  PC <= popped address.
- ALU_zero  in  1  ALU zero flag.
- Target  in  PC_W  absolute address or two's-complement offset.
- PC  out  PC_W  program counter.
- DONE  out  1  current program halted.
- ALL_DONE  out  1  last program halted.
- PROG_IDX  out  $clog2(NUM_PROG)+1  index of the program to run next / currently running.
- RAS_ERR  out  1  sticky stack overflow/underflow.

Behaviour:
- Reset (Init=1): state RUN, PROG_IDX=0, PC=PROG_START[0], DONE=0, ALL_DONE=0, RAS empty, RAS_ERR=0. Init overrides every other input.
- States: RUN, HALTED, FINISHED.
- RUN, PC==DONE_ADDR at the edge (checked regardless of Stall or branch inputs): PC holds, DONE<=1.
  - If PROG_IDX<NUM_PROG-1: PROG_IDX+1 and go to HALTED.
  - Else: ALL_DONE<=1 and go to FINISHED; PROG_IDX unchanged.
- HALTED: PC holds and branch inputs are ignored.
  - Start=1: PC<=PROG_START[PROG_IDX], DONE<=0, RAS cleared, go to RUN. RAS_ERR is preserved.
- FINISHED: everything holds; Start is ignored; only Init exits.
- RUN, not at DONE_ADDR, one action per edge in priority order:
  - Stall: hold.
  - Branch_ret:
    - RAS non-empty: PC<=top and pop.
    - RAS empty: RAS_ERR<=1, PC<=PC+1.
  - Branch_call:
    - RAS not full: push PC+1, PC<=Target.
    - RAS full: RAS_ERR<=1, no push, PC<=Target anyway.
  - Branch_abs: PC<=Target.
  - Branch_rel_z && ALU_zero: PC<=PC+Target.
  - Branch_rel_nz && !ALU_zero: PC<=PC+Target.
  - Otherwise: PC<=PC+1.
- A conditional branch whose condition fails falls through to PC+1; it does not block lower-priority entries.
- Arithmetic: all PC math is modulo 2^PC_W. Target is signed for relative jumps (wrap-around allowed, no flag). PC+1 at all-ones wraps to 0.
- RAS is LIFO, depth RAS_DEPTH; the pushed value is PC+1 modulo 2^PC_W.
- Latency: PC changes one cycle after the controlling inputs. DONE/ALL_DONE assert in the cycle after PC first equals DONE_ADDR.
- Start and branch inputs asserted in the same cycle while HALTED: Start wins; branches are ignored.

Test Plan:
- Init=1 for 1 cycle, then 3 free-running cycles -> PC=66,67,68,69; DONE=0, PROG_IDX=0.
- Branch_abs with Target=999 -> PC=999, DONE=1 next cycle, PROG_IDX=1, PC stays 999 for 5 cycles. Then Start -> PC=124, DONE=0.
- Drive programs 0,1,2 to 999 with Start between each -> after the third halt ALL_DONE=1 and PROG_IDX=2. Further Start has no effect; Init -> PC=66, ALL_DONE=0.
- PC=70, Branch_rel_nz with ALU_zero=0, Target=16'hFFFB -> PC=65. Same with ALU_zero=1 -> PC=71. Branch_rel_z with ALU_zero=1, Target=5 -> PC=PC+5.
- RAS_DEPTH=4: from PC=80 issue 5 calls to Target=200 -> first 4 push 81,201,201,201; fifth sets RAS_ERR=1, PC=200. Then 5 rets -> PC=201,201,201,81, then underflow gives PC=82, RAS_ERR stays 1.
- Stall=1 with Branch_abs, Target=10 at PC=90 -> PC stays 90. Stall at PC=999 -> halt still detected.
